// File: rtl/fftstream_fifo.sv
// Synchronous show-ahead FIFO used as the elastic buffer of fftstream_out.
//
// The head entry is presented on o_data combinationally from the storage
// array, so a word written into an empty FIFO is visible on the next cycle.
// Pointers wrap modulo the depth. The fill counter is the only source of
// full/empty, so no extra pointer bit is needed.
//
// Parameters:
//   DW      entry width in bits
//   LGFLEN  log2 of the FIFO depth (>= 1)
//
// Ports:
//   i_clk    clock, all state on posedge
//   i_reset  asynchronous active-high reset; empties the FIFO
//   i_wr     write request; accepted when not full, or when full and
//            a read happens in the same cycle
//   i_data   write data
//   o_full   fill == depth
//   i_rd     read request; ignored while empty
//   o_data   head entry (zero while empty)
//   o_empty  fill == 0
//   o_fill   current occupancy, 0..depth
module fftstream_fifo #(
  parameter int DW     = 8,
  parameter int LGFLEN = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr,
  input  logic [DW-1:0]     i_data,
  output logic              o_full,
  input  logic              i_rd,
  output logic [DW-1:0]     o_data,
  output logic              o_empty,
  output logic [LGFLEN:0]   o_fill
);

  localparam int DEPTH = 1 << LGFLEN;
  localparam logic [LGFLEN:0] FULL_CNT = {1'b1, {LGFLEN{1'b0}}};

  logic [DW-1:0]     mem [DEPTH];
  logic [LGFLEN-1:0] wr_ptr;
  logic [LGFLEN-1:0] rd_ptr;
  logic [LGFLEN:0]   fill;
  logic              wr_en;
  logic              rd_en;

  assign o_full  = (fill == FULL_CNT);
  assign o_empty = (fill == '0);
  assign o_fill  = fill;

  // A write into a full FIFO is legal only when the head leaves in the
  // same cycle; the write then lands in the slot being vacated.
  assign wr_en = i_wr && (!o_full || i_rd);
  assign rd_en = i_rd && !o_empty;

  // Gate the head so the output reads zero while nothing is buffered.
  assign o_data = o_empty ? '0 : mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

endmodule

// File: rtl/fftstream_out.sv
// Output adapter behind the FFT bit-reverse stage.
//
// Converts the CE-paced, unstallable sample stream (sample + frame sync)
// into a valid/ready stream with a frame-end marker. Samples are buffered
// in fftstream_fifo so the consumer can stall; if the FIFO is full the
// sample is dropped and the block resynchronises on the next frame sync.
//
// Handshake: o_valid/o_data/o_last describe the FIFO head; a transfer
// happens on a clock edge where o_valid && i_ready. While o_valid is high
// and i_ready is low, o_data and o_last do not change.
//
// Parameters:
//   WIDTH   bits per real/imag component (sample is 2*WIDTH bits)
//   LGSIZE  log2 of the frame length
//   LGFIFO  log2 of the FIFO depth (>= 1)
//
// Ports:
//   i_clk, i_reset  clock and asynchronous active-high reset
//   i_ce            input sample strobe
//   i_sample        {real, imag} sample
//   i_sync          first sample of a frame (qualified by i_ce)
//   o_valid         output sample available
//   i_ready         consumer accepts the current output sample
//   o_data          output sample
//   o_last          final sample of a frame
//   o_fill          FIFO occupancy
//   o_overflow      sticky: a sample was dropped on a full FIFO
//   o_sync_err      sticky: sync arrived mid-frame
module fftstream_out #(
  parameter int WIDTH  = 24,
  parameter int LGSIZE = 5,
  parameter int LGFIFO = 5
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_ce,
  input  logic [2*WIDTH-1:0]   i_sample,
  input  logic                 i_sync,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [2*WIDTH-1:0]   o_data,
  output logic                 o_last,
  output logic [LGFIFO:0]      o_fill,
  output logic                 o_overflow,
  output logic                 o_sync_err
);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_RUN  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  localparam logic [LGSIZE-1:0] LAST_IDX = '1;
  localparam logic [LGSIZE-1:0] IDX_ONE  = {{(LGSIZE-1){1'b0}}, 1'b1};

  state_t              state;
  state_t              state_nx;
  logic [LGSIZE-1:0]   count;
  logic [LGSIZE-1:0]   count_nx;
  logic [LGSIZE-1:0]   idx;
  logic                accept;
  logic                wr;
  logic                rd;
  logic                drop;
  logic                sync_hit;
  logic                full;
  logic                empty;
  logic [2*WIDTH:0]    fifo_out;

  assign rd      = !empty && i_ready;
  assign o_valid = !empty;
  assign o_last  = fifo_out[2*WIDTH];
  assign o_data  = fifo_out[2*WIDTH-1:0];

  // idx is the frame position of the current i_ce sample; count holds the
  // position the next sample will take.
  always_comb begin
    state_nx = state;
    count_nx = count;
    idx      = count;
    accept   = 1'b0;
    wr       = 1'b0;
    drop     = 1'b0;
    sync_hit = 1'b0;
    case (state)
      S_RUN: begin
        if (i_ce) begin
          accept = 1'b1;
          if (i_sync) begin
            idx      = '0;
            sync_hit = (count != '0);
          end
        end
      end
      default: begin
        // S_WAIT and S_DROP: only a sync sample starts a new frame.
        if (i_ce && i_sync) begin
          accept = 1'b1;
          idx    = '0;
        end
      end
    endcase
    if (accept) begin
      if (full && !rd) begin
        drop     = 1'b1;
        state_nx = S_DROP;
        count_nx = '0;
      end else begin
        wr       = 1'b1;
        state_nx = S_RUN;
        count_nx = idx + IDX_ONE;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= S_WAIT;
      count      <= '0;
      o_overflow <= 1'b0;
      o_sync_err <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      if (drop)     o_overflow <= 1'b1;
      if (sync_hit) o_sync_err <= 1'b1;
    end
  end

  fftstream_fifo #(
    .DW     (2*WIDTH+1),
    .LGFLEN (LGFIFO)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_wr    (wr),
    .i_data  ({(idx == LAST_IDX), i_sample}),
    .o_full  (full),
    .i_rd    (rd),
    .o_data  (fifo_out),
    .o_empty (empty),
    .o_fill  (o_fill)
  );

endmodule
